// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared state and mode encodings for the step controller and debug unit
package mips_dbg_pkg;

  // Execution controller state encoding, 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } step_state_t;

  // Execution mode selected at start
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  // True in states where the pipeline is considered active
  function automatic logic state_is_running(input step_state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/mips_step_control.sv
// rtl/mips_step_control.sv - pipeline step/flush controller with single-step and cycle counter
module mips_step_control
  import mips_dbg_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic             i_Mode,
  input  logic             i_StepReq,
  input  logic             i_HALT,
  input  logic             i_BranchTaken,
  output logic             o_Step,
  output logic             o_Flush,
  output logic             o_Running,
  output logic             o_Done,
  output logic             o_StepAck,
  output logic [NBITS-1:0] o_Cycles
);

  step_state_t state;
  step_state_t state_next;
  logic        mode_reg;
  logic        mode_next;

  // State and latched mode register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      mode_reg <= MODE_CONT;
    end else begin
      state    <= state_next;
      mode_reg <= mode_next;
    end
  end

  // Next-state and combinational outputs; HALT gates stepping in the same cycle
  always_comb begin
    state_next = state;
    mode_next  = mode_reg;
    o_Step     = 1'b0;
    o_Flush    = 1'b0;
    o_Running  = state_is_running(state);
    o_Done     = (state == ST_DONE);

    unique case (state)
      ST_IDLE: begin
        if (i_Start) begin
          mode_next  = i_Mode;
          state_next = (i_Mode == MODE_STEP) ? ST_PAUSE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_HALT) state_next = ST_DONE;
      end
      ST_PAUSE: begin
        if (i_HALT)         state_next = ST_DONE;
        else if (i_StepReq) state_next = ST_STEP;
      end
      ST_STEP: begin
        // A step lasts one cycle; a request arriving now is dropped, not queued.
        // STEP is only reachable in single-step mode, so this returns to PAUSE.
        state_next = (mode_reg == MODE_STEP) ? ST_PAUSE : ST_RUN;
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    o_Step  = ((state == ST_RUN) || (state == ST_STEP)) && !i_HALT;
    // Pipeline registers favour flush over step, so only flush when advancing
    o_Flush = i_BranchTaken && o_Step;
  end

  // Acknowledge a single step one cycle after it actually advanced the pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) o_StepAck <= 1'b0;
    else         o_StepAck <= (state == ST_STEP) && o_Step;
  end

  // Saturating count of cycles in which the pipeline advanced
  always_ff @(posedge i_clk) begin
    if (i_reset)                          o_Cycles <= '0;
    else if (o_Step && (o_Cycles != '1))  o_Cycles <= o_Cycles + 1'b1;
  end

endmodule

// File: tb/tb_mips_step_control.sv
// tb/tb_mips_step_control.sv - directed self-checking bench for mips_step_control
module tb_mips_step_control;

  localparam int NBITS = 4;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_Start;
  logic             i_Mode;
  logic             i_StepReq;
  logic             i_HALT;
  logic             i_BranchTaken;
  logic             o_Step;
  logic             o_Flush;
  logic             o_Running;
  logic             o_Done;
  logic             o_StepAck;
  logic [NBITS-1:0] o_Cycles;

  int tests  = 0;
  int failed = 0;

  mips_step_control #(.NBITS(NBITS)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_Start       (i_Start),
    .i_Mode        (i_Mode),
    .i_StepReq     (i_StepReq),
    .i_HALT        (i_HALT),
    .i_BranchTaken (i_BranchTaken),
    .o_Step        (o_Step),
    .o_Flush       (o_Flush),
    .o_Running     (o_Running),
    .o_Done        (o_Done),
    .o_StepAck     (o_StepAck),
    .o_Cycles      (o_Cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven at the falling edge
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    int step_cnt;
    int ack_cnt;
    bit exp_step;
    bit exp_ack;

    i_reset = 1'b0; i_Start = 1'b0; i_Mode = 1'b0; i_StepReq = 1'b0;
    i_HALT = 1'b0; i_BranchTaken = 1'b0;
    @(negedge i_clk);

    // Reset state
    do_reset();
    check("rst_step",    o_Step,    0);
    check("rst_flush",   o_Flush,   0);
    check("rst_running", o_Running, 0);
    check("rst_done",    o_Done,    0);
    check("rst_ack",     o_StepAck, 0);
    check("rst_cycles",  o_Cycles,  0);

    // Continuous run, HALT 10 cycles after Start
    i_Start = 1'b1; i_Mode = 1'b0;
    #1 check("idle_step", o_Step, 0);
    tick();
    i_Start = 1'b0;
    step_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      i_HALT        = (c == 10);
      i_BranchTaken = (c == 3);
      #1;
      step_cnt += int'(o_Step);
      if (c == 1) check("run_running", o_Running, 1);
      if (c == 3) check("run_flush", o_Flush, 1);
      if (c == 4) check("run_noflush", o_Flush, 0);
      if (c == 10) check("halt_masks_step", o_Step, 0);
      tick();
    end
    i_HALT = 1'b0;
    #1;
    check("cont_steps",  step_cnt,  9);
    check("cont_cycles", o_Cycles,  9);
    check("cont_done",   o_Done,    1);
    check("cont_notrun", o_Running, 0);
    check("done_step",   o_Step,    0);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    #1;
    check("done_ignores_start", o_Done, 1);
    check("done_holds_cycles",  o_Cycles, 9);

    // Single-step mode, three requests 5 cycles apart
    do_reset();
    i_Start = 1'b1; i_Mode = 1'b1;
    tick();
    i_Start = 1'b0; i_Mode = 1'b0;
    i_BranchTaken = 1'b1;
    #1;
    check("pause_running", o_Running, 1);
    check("pause_step",    o_Step,    0);
    check("pause_noflush", o_Flush,   0);
    i_BranchTaken = 1'b0;
    step_cnt = 0;
    ack_cnt  = 0;
    for (int c = 0; c < 16; c++) begin
      i_StepReq = (c == 0) || (c == 5) || (c == 10);
      #1;
      exp_step = (c == 1) || (c == 6) || (c == 11);
      exp_ack  = (c == 2) || (c == 7) || (c == 12);
      check($sformatf("ss_step_c%0d", c), o_Step,    int'(exp_step));
      check($sformatf("ss_ack_c%0d", c),  o_StepAck, int'(exp_ack));
      step_cnt += int'(o_Step);
      ack_cnt  += int'(o_StepAck);
      tick();
    end
    i_StepReq = 1'b0;
    #1;
    check("ss_steps",  step_cnt, 3);
    check("ss_acks",   ack_cnt,  3);
    check("ss_cycles", o_Cycles, 3);

    // Request held across the STEP cycle yields one step only
    i_StepReq = 1'b1;
    #1 check("hold_c0_step", o_Step, 0);
    tick();
    i_BranchTaken = 1'b1;
    #1;
    check("hold_c1_step",  o_Step,  1);
    check("hold_c1_flush", o_Flush, 1);
    tick();
    i_StepReq = 1'b0; i_BranchTaken = 1'b0;
    #1 check("hold_c2_step", o_Step, 0);
    tick();
    #1;
    check("hold_c3_step", o_Step,   0);
    check("hold_cycles",  o_Cycles, 4);

    // HALT beats StepReq in PAUSE
    i_HALT = 1'b1; i_StepReq = 1'b1;
    #1 check("hp_step", o_Step, 0);
    tick();
    i_StepReq = 1'b0;
    #1;
    check("hp_done", o_Done, 1);
    check("hp_step_after", o_Step, 0);
    tick();
    i_HALT = 1'b0;
    #1;
    check("hp_ack",    o_StepAck, 0);
    check("hp_cycles", o_Cycles,  4);

    // Saturation with a 4-bit counter, then reset mid-run
    do_reset();
    i_Start = 1'b1; i_Mode = 1'b0;
    tick();
    i_Start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    #1;
    check("sat_cycles",  o_Cycles,  15);
    check("sat_running", o_Running, 1);
    check("sat_step",    o_Step,    1);
    do_reset();
    check("mid_rst_cycles",  o_Cycles,  0);
    check("mid_rst_step",    o_Step,    0);
    check("mid_rst_running", o_Running, 0);
    tick();
    #1;
    check("post_rst_step",   o_Step,    0);
    check("post_rst_cycles", o_Cycles,  0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
